// File: rtl/cfu_requant_pkg.sv
// Shared opcodes, FSM state encoding and rounding constants for the int8
// requantization CFU.
package cfu_requant_pkg;

  localparam logic [6:0] OP_REQUANT   = 7'd0;
  localparam logic [6:0] OP_SET_MS    = 7'd1;
  localparam logic [6:0] OP_SET_OFS   = 7'd2;
  localparam logic [6:0] OP_READ_MULT = 7'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_MUL0,
    S_MUL1,
    S_RND,
    S_DIV,
    S_OUT,
    S_RSP
  } state_t;

  // Nudges for SaturatingRoundingDoublingHighMul (round half away from zero)
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

endpackage

// File: rtl/cfu_requant_rdbpot.sv
// Combinational RoundingDivideByPOT: val / 2^exp_e, rounded half away from zero.
module requant_rdbpot (
  input  logic signed [31:0] val,
  input  logic        [4:0]  exp_e,
  output logic signed [31:0] res
);

  logic        [31:0] mask;
  logic        [31:0] rem;
  logic        [31:0] thr;
  logic signed [31:0] shifted;

  always_comb begin
    mask    = (32'd1 << exp_e) - 32'd1;
    rem     = val & mask;
    thr     = (mask >> 1) + {31'd0, val[31]};
    // kept in its own statement so the shift stays arithmetic
    shifted = val >>> exp_e;
    res     = shifted + $signed({31'd0, (rem > thr)});
  end

endmodule

// File: rtl/cfu_requant.sv
// int32 accumulator + bias -> int8 requantizer (TFLM semantics) on the CFU
// cmd/rsp handshake, with a fixed seven-cycle pipeline for REQUANT.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PRE   | x = (acc + bias) << left shift
// MUL0  | low partial product x * mult[15:0]
// MUL1  | high partial product combined into 64-bit ab
// RND   | saturating rounding doubling high multiply -> y
// DIV   | rounding divide by 2^right shift -> z
// OUT   | add output offset, clamp to activation range
// RSP   | response held until rsp_ready
module cfu_requant
  import cfu_requant_pkg::*;
#(
  parameter logic        [31:0] DEF_MULT       = 32'h4000_0000,
  parameter logic signed [5:0]  DEF_SHIFT      = 6'sd0,
  parameter logic signed [15:0] DEF_OUT_OFFSET = -16'sd128,
  parameter logic signed [7:0]  DEF_ACT_MIN    = -8'sd128,
  parameter logic signed [7:0]  DEF_ACT_MAX    = 8'sd127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  state_t state;

  logic        [31:0] mult;
  logic signed [5:0]  shift;
  logic signed [15:0] out_offset;
  logic signed [7:0]  act_min;
  logic signed [7:0]  act_max;

  logic signed [31:0] sum;
  logic signed [31:0] x;
  logic signed [48:0] p_lo;
  logic signed [63:0] ab;
  logic signed [31:0] y;
  logic signed [31:0] z;

  logic [6:0] funct7;
  assign funct7 = cmd_payload_function_id[9:3];

  // Shift decode: positive shifts scale the input, negative ones round-divide
  logic [4:0] lsh;
  logic [5:0] neg_shift;
  logic [4:0] rsh;

  always_comb begin
    lsh       = shift[5] ? 5'd0 : shift[4:0];
    neg_shift = 6'd0 - shift;
    if (!shift[5])
      rsh = 5'd0;
    else if (neg_shift[5])
      rsh = 5'd31;
    else
      rsh = neg_shift[4:0];
  end

  logic signed [31:0] x_next;
  logic signed [16:0] mult_lo_s;
  logic signed [15:0] mult_hi_s;
  logic signed [48:0] p_lo_next;
  logic signed [47:0] p_hi;
  logic signed [63:0] ab_next;

  always_comb begin
    x_next    = sum << lsh;
    mult_lo_s = {1'b0, mult[15:0]};
    mult_hi_s = mult[31:16];
    p_lo_next = x * mult_lo_s;
    p_hi      = x * mult_hi_s;
    ab_next   = {p_hi, 16'h0000} + {{15{p_lo[48]}}, p_lo};
  end

  logic signed [63:0] nudged;
  logic signed [63:0] trunc_adj;
  logic signed [63:0] rnd_tot;
  logic signed [63:0] quo;
  logic               sat;
  logic signed [31:0] y_next;

  always_comb begin
    nudged    = ab + (ab[63] ? NUDGE_NEG : NUDGE_POS);
    // bias negative values up so the arithmetic shift truncates toward zero
    trunc_adj = nudged[63] ? 64'sh7FFF_FFFF : 64'sh0;
    rnd_tot   = nudged + trunc_adj;
    quo       = rnd_tot >>> 31;
    sat       = (x == INT32_MIN) && (mult == INT32_MIN);
    y_next    = sat ? INT32_MAX : quo[31:0];
  end

  logic signed [31:0] z_next;

  requant_rdbpot u_rdbpot (
    .val   (y),
    .exp_e (rsh),
    .res   (z_next)
  );

  logic signed [31:0] w;
  logic signed [31:0] min32;
  logic signed [31:0] max32;
  logic signed [31:0] lo_clamped;
  logic signed [31:0] clamped;
  logic        [31:0] result;

  // min is applied before max, so an inverted range yields act_max
  always_comb begin
    w          = z + {{16{out_offset[15]}}, out_offset};
    min32      = {{24{act_min[7]}}, act_min};
    max32      = {{24{act_max[7]}}, act_max};
    lo_clamped = (w < min32) ? min32 : w;
    clamped    = (lo_clamped > max32) ? max32 : lo_clamped;
    result     = {{24{clamped[7]}}, clamped[7:0]};
  end

  logic unused_bits;
  assign unused_bits = ^{cmd_payload_function_id[2:0], quo[63:32], clamped[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_IDLE;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= 32'd0;
      mult                  <= DEF_MULT;
      shift                 <= DEF_SHIFT;
      out_offset            <= DEF_OUT_OFFSET;
      act_min               <= DEF_ACT_MIN;
      act_max               <= DEF_ACT_MAX;
      sum                   <= 32'sd0;
      x                     <= 32'sd0;
      p_lo                  <= 49'sd0;
      ab                    <= 64'sd0;
      y                     <= 32'sd0;
      z                     <= 32'sd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (funct7 == OP_REQUANT) begin
              sum   <= cmd_payload_inputs_0 + cmd_payload_inputs_1;
              state <= S_PRE;
            end else begin
              state     <= S_RSP;
              rsp_valid <= 1'b1;
              case (funct7)
                OP_SET_MS: begin
                  mult                  <= cmd_payload_inputs_0;
                  shift                 <= cmd_payload_inputs_1[5:0];
                  rsp_payload_outputs_0 <= 32'd0;
                end
                OP_SET_OFS: begin
                  out_offset            <= cmd_payload_inputs_0[15:0];
                  act_min               <= cmd_payload_inputs_1[7:0];
                  act_max               <= cmd_payload_inputs_1[15:8];
                  rsp_payload_outputs_0 <= 32'd0;
                end
                OP_READ_MULT: rsp_payload_outputs_0 <= mult;
                default:      rsp_payload_outputs_0 <= 32'd0;
              endcase
            end
          end
        end
        S_PRE: begin
          x     <= x_next;
          state <= S_MUL0;
        end
        S_MUL0: begin
          p_lo  <= p_lo_next;
          state <= S_MUL1;
        end
        S_MUL1: begin
          ab    <= ab_next;
          state <= S_RND;
        end
        S_RND: begin
          y     <= y_next;
          state <= S_DIV;
        end
        S_DIV: begin
          z     <= z_next;
          state <= S_OUT;
        end
        S_OUT: begin
          rsp_payload_outputs_0 <= result;
          rsp_valid             <= 1'b1;
          state                 <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_requant.sv
// Scoreboard bench for cfu_requant: random and directed commands against a
// plain-arithmetic TFLM requantization model.
module tb_cfu_requant;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;

  cfu_requant dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] exp;
    int          n;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // reference configuration
  int m_mult, m_shift, m_ofs, m_min, m_max;

  task automatic model_reset();
    m_mult = 32'h4000_0000; m_shift = 0; m_ofs = -128; m_min = -128; m_max = 127;
  endtask

  function automatic int model_requant(int acc, int bias);
    int x, y, z, w, t, lsh, e;
    longint ab, nudge, q, r;
    lsh = (m_shift > 0) ? m_shift : 0;
    e   = (m_shift < 0) ? -m_shift : 0;
    x = (acc + bias) << lsh;
    if (x == 32'h8000_0000 && m_mult == 32'h8000_0000) begin
      y = 32'h7FFF_FFFF;
    end else begin
      ab    = longint'(x) * longint'(m_mult);
      nudge = (ab >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
      y = int'((ab + nudge) / (longint'(1) << 31));
    end
    if (e == 0) begin
      z = y;
    end else begin
      q = (y < 0) ? -longint'(y) : longint'(y);
      r = (q + (longint'(1) << (e - 1))) >> e;
      z = (y < 0) ? int'(-r) : int'(r);
    end
    w = z + m_ofs;
    t = (w < m_min) ? m_min : w;
    t = (t > m_max) ? m_max : t;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one command, hold it until accepted, and queue the expected response.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    logic signed [5:0] s6;
    logic signed [15:0] s16;
    logic signed [7:0] s8a, s8b;
    exp_t item;
    int k;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'(op), 3'($urandom_range(0, 7))};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    for (k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    item.n = cyc;
    case (op)
      0: begin exp = model_requant(a, b); item.lat = 7; end
      1: begin s6 = b[5:0]; m_mult = a; m_shift = s6; exp = 0; item.lat = 1; end
      2: begin
        s16 = a[15:0]; s8a = b[7:0]; s8b = b[15:8];
        m_ofs = s16; m_min = s8a; m_max = s8b; exp = 0; item.lat = 1;
      end
      3: begin exp = m_mult; item.lat = 1; end
      default: begin exp = 0; item.lat = 1; end
    endcase
    item.exp = exp;
    @(posedge clk);
    #1;
    sb.push_back(item);
    cmd_valid = 1'b0;
  endtask

  // rsp_ready changes just after the active edge so it is stable at negedge
  bit force_lo = 1'b0;
  always begin
    @(posedge clk);
    #1;
    rsp_ready = force_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  bit in_rsp = 1'b0;
  logic [31:0] cur_exp;
  always @(negedge clk) begin
    if (reset) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", rsp_payload_outputs_0, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          cur_exp = e.exp;
          chk("rsp_payload", rsp_payload_outputs_0, e.exp);
          chk("rsp_latency", 32'(cyc - e.n), 32'(e.lat));
        end
        in_rsp = 1'b1;
      end else begin
        chk("rsp_stable", rsp_payload_outputs_0, cur_exp);
      end
      chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (rsp_ready) in_rsp = 1'b0;
    end
  end

  task automatic drain();
    int k;
    for (k = 0; k < 300 && (sb.size() != 0 || in_rsp || rsp_valid); k++) @(negedge clk);
    if (sb.size() != 0 || in_rsp || rsp_valid)
      chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int op, k, n;
    logic [31:0] a, b;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_payload", rsp_payload_outputs_0, 32'd0);

    // defaults: 100 -> y=50, +(-128) -> -78
    issue(0, 32'd100, 32'd0);
    chk("model_default", model_requant(100, 0), 32'hFFFF_FFB2);
    issue(1, 32'h4000_0000, 32'h3F);
    issue(2, 32'd0, {16'd0, 8'sd127, -8'sd128});
    issue(0, 32'd1000, 32'd24);
    issue(1, 32'h7FFF_FFFF, 32'h3F);
    issue(0, -32'sd3, 32'd0);
    issue(1, 32'h8000_0000, 32'd0);
    issue(0, 32'h8000_0000, 32'd0);
    issue(3, 32'd0, 32'd0);
    issue(2, 32'd0, {16'd0, 8'sd10, 8'sd20});
    issue(0, 32'd0, 32'd0);
    issue(77, 32'hDEAD_BEEF, 32'h1234_5678);
    drain();

    // stalled response: rsp_ready low for three cycles after rsp_valid rises
    force_lo = 1'b1;
    issue(1, 32'h4000_0000, 32'd2);
    force_lo = 1'b0;
    drain();
    force_lo = 1'b1;
    issue(2, 32'd5, {16'd0, 8'sd127, -8'sd128});
    force_lo = 1'b0;
    drain();
    force_lo = 1'b1;
    issue(0, 32'd10, 32'd0);
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_valid", {31'd0, rsp_valid}, 32'd1);
    end
    force_lo = 1'b0;
    drain();

    // reset while a REQUANT is in flight: no response, defaults restored
    issue(1, 32'h1234_5678, 32'd3);
    drain();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd0, 3'd0};
    cmd_payload_inputs_0 = 32'd500;
    cmd_payload_inputs_1 = 32'd7;
    for (k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
    n = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (cyc < n + 3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (10) @(negedge clk);
    issue(3, 32'd0, 32'd0);
    drain();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 99);
      if (k < 50) begin
        op = 0;
        a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(17'($urandom_range(0, 131071))) - 65536);
        b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 4095)) - 32'd2048;
      end else if (k < 65) begin
        op = 1;
        a = ($urandom_range(0, 1) == 0) ? $urandom : 32'h4000_0000 + $urandom_range(0, 65535);
        b = 32'($urandom_range(0, 62)) - 32'd31;
      end else if (k < 80) begin
        op = 2;
        a = $urandom;
        if ($urandom_range(0, 2) == 0) b = $urandom;
        else b = {16'd0, 8'($urandom_range(0, 127)), 8'($urandom_range(128, 255))};
      end else if (k < 90) begin
        op = 3; a = $urandom; b = $urandom;
      end else begin
        op = $urandom_range(4, 127); a = $urandom; b = $urandom;
      end
      issue(op, a, b);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
